sevenseg_scan_ctrl: RTL and testbench
=====================================

Name: sevenseg_scan_ctrl

Overview:
- Port-mapped 4-digit seven-segment display controller downstream of the PicoBlaze (kcpsm6) output port.
- Captures digit values, blank mask and decimal-point mask from OUTPUT instructions (port_id / out_port / write_strobe).
- Time-multiplexes the four digits onto one active-low segment bus and four active-low digit enables.
- Adds an anti-ghosting dead time at the start of each digit slot.

Parameters:
- BASE_PORT, 8'h83, port_id of digit 0. Map: BASE+0..BASE+3 = digits 0..3, BASE+4 = blank mask, BASE+5 = dp mask.
- REFRESH_DIV, 1024, clk cycles per digit slot; must be >= 2.
- GHOST_CYCLES, 16, cycles at the start of each slot during which all enables are off; must be < REFRESH_DIV.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- port_id  input  8  PicoBlaze port address.
- out_port  input  8  PicoBlaze output data.
- write_strobe  input  1  one-cycle qualifier for out_port/port_id.
- seg  output  8  {dp,g,f,e,d,c,b,a}, active-low, registered.
- en  output  4  digit enables, active-low, registered; en[i] drives digit i.
- slot_tick  output  1  one-cycle pulse, registered, asserted on the cycle the digit index advances.

Behaviour:
- Reset (rst high at a rising edge) produces:
  - digit regs = 0, blank mask = 4'b0000, dp mask = 4'b0000;
  - refresh counter = 0, digit index = 0;
  - seg = 8'hFF, en = 4'b1111, slot_tick = 0.
  - rst has priority over a simultaneous write_strobe.
- Register writes, on a rising edge with write_strobe = 1:
  - port_id = BASE+i (i = 0..3): digit[i] <= out_port[3:0]; out_port[7:4] is ignored.
  - port_id = BASE+4: blank[3:0] <= out_port[3:0]. A 1 bit forces that digit dark (en bit stays 1).
  - port_id = BASE+5: dp[3:0] <= out_port[3:0]. A 1 bit lights the dp of that digit.
  - Any other port_id: no effect.
  - write_strobe = 0: no register change, whatever port_id is.
- Scan counter:
  - Counts 0..REFRESH_DIV-1 and wraps to 0.
  - On the wrap edge, index <= (index+1) mod 4 and slot_tick = 1 for exactly one cycle. 3 wraps to 0.
- State machine, per slot:
  - DEAD while counter < GHOST_CYCLES: en = 4'b1111, seg = 8'hFF.
  - DRIVE for the rest of the slot: en = ~(1 << index), unless blank[index] = 1, in which case en = 4'b1111 and seg = 8'hFF.
  - DRIVE: seg = {~dp[index], hexdecode(digit[index])}.
- seg and en are computed from the current counter/index/regs and registered, so they lag state by one clock.
- Write latency: a register written at edge N appears on seg at edge N+1 if that digit is in DRIVE.
  - A write to the digit currently displayed updates mid-slot, with no glitch beyond that one edge.
- Hex decode, active-low gfedcba, full 0-F:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
- Reset mid-slot: on the next edge the counter and index restart at 0 and outputs go dark.
  - The first DRIVE begins GHOST_CYCLES+1 edges after rst deasserts.
- Never more than one en bit low at a time.

Test Plan:
(Bench uses REFRESH_DIV=8, GHOST_CYCLES=2, BASE_PORT=8'h83.)
- Reset, then no writes.
  - Expected: slot_tick every 8 cycles; en cycles 1110,1101,1011,0111 with 1111 during the first 2 cycles of each slot; seg=8'hC0 whenever any en is low.
- Writes 83<=03, 84<=1A, 85<=2F, 86<=38, then run one full scan.
  - Expected during DRIVE: digit0 seg=8'hB0, digit1 8'h88, digit2 8'h8E, digit3 8'h80 (upper nibbles ignored).
- Write 87<=05 (blank mask), then write 88<=02 (dp mask).
  - After the blank write: en never 1110 or 1011; digits 0 and 2 are dark.
  - After the dp write: digit1 seg bit7 = 0.
- Write port 8'h90 and port 8'h82 with data 8'h07, and drive port_id=8'h83 with write_strobe=0.
  - Expected: no change to any displayed value.
- While digit0 is in DRIVE showing 0, write 83<=09 at edge N.
  - Expected: seg=8'h90 from edge N+1; en unchanged; slot timing unchanged.
- Assert rst for 1 cycle mid-slot on digit 2, together with write_strobe to 85.
  - Expected: digit2 stays 0; en=1111 and seg=FF next edge; en=1110 first appears at the 3rd edge after rst deasserts.

Source files
------------

// File: rtl/sevenseg_scan_ctrl.sv
// Four-digit multiplexed seven-segment controller fed from PicoBlaze OUTPUT writes.
// Each digit slot starts with an all-dark dead time to suppress ghosting between digits.
module sevenseg_scan_ctrl #(
  parameter logic [7:0]  BASE_PORT    = 8'h83,
  parameter int unsigned REFRESH_DIV  = 1024,
  parameter int unsigned GHOST_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] port_id,
  input  logic [7:0] out_port,
  input  logic       write_strobe,
  output logic [7:0] seg,
  output logic [3:0] en,
  output logic       slot_tick
);

  localparam int unsigned    CW        = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0]  CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0]  GHOST_END = CW'(GHOST_CYCLES);

  localparam logic [7:0] P_D0    = BASE_PORT;
  localparam logic [7:0] P_D1    = BASE_PORT + 8'd1;
  localparam logic [7:0] P_D2    = BASE_PORT + 8'd2;
  localparam logic [7:0] P_D3    = BASE_PORT + 8'd3;
  localparam logic [7:0] P_BLANK = BASE_PORT + 8'd4;
  localparam logic [7:0] P_DP    = BASE_PORT + 8'd5;

  typedef enum logic {DEAD, DRIVE} phase_t;

  // With no ghost time, a slot is in DRIVE from its very first cycle.
  localparam phase_t RST_PHASE = (GHOST_CYCLES == 0) ? DRIVE : DEAD;

  phase_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [1:0]    idx, idx_next;
  logic          wrap;
  logic [3:0]    digit [4];
  logic [3:0]    blank, dp;
  logic [7:0]    seg_d;
  logic [3:0]    en_d;
  logic          unused_hi;

  assign unused_hi = &{1'b0, out_port[7:4]};

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] r;
    case (v)
      4'h0: r = 7'h40;
      4'h1: r = 7'h79;
      4'h2: r = 7'h24;
      4'h3: r = 7'h30;
      4'h4: r = 7'h19;
      4'h5: r = 7'h12;
      4'h6: r = 7'h02;
      4'h7: r = 7'h78;
      4'h8: r = 7'h00;
      4'h9: r = 7'h10;
      4'hA: r = 7'h08;
      4'hB: r = 7'h03;
      4'hC: r = 7'h46;
      4'hD: r = 7'h21;
      4'hE: r = 7'h06;
      default: r = 7'h0E;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 4; i++) digit[i] <= '0;
      blank <= '0;
      dp    <= '0;
    end else if (write_strobe) begin
      case (port_id)
        P_D0:    digit[0] <= out_port[3:0];
        P_D1:    digit[1] <= out_port[3:0];
        P_D2:    digit[2] <= out_port[3:0];
        P_D3:    digit[3] <= out_port[3:0];
        P_BLANK: blank    <= out_port[3:0];
        P_DP:    dp       <= out_port[3:0];
        default: ;
      endcase
    end
  end

  // Phase is registered alongside the counter so it always matches cnt < GHOST_END.
  always_comb begin
    wrap       = (cnt == CNT_LAST);
    cnt_next   = wrap ? '0 : cnt + 1'b1;
    idx_next   = wrap ? idx + 2'd1 : idx;
    state_next = (cnt_next < GHOST_END) ? DEAD : DRIVE;
    seg_d      = '1;
    en_d       = '1;
    if (state == DRIVE && !blank[idx]) begin
      en_d  = ~(4'b0001 << idx);
      seg_d = {~dp[idx], hex7(digit[idx])};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RST_PHASE;
      cnt       <= '0;
      idx       <= '0;
      seg       <= '1;
      en        <= '1;
      slot_tick <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      idx       <= idx_next;
      seg       <= seg_d;
      en        <= en_d;
      slot_tick <= wrap;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Randomized and directed checks of sevenseg_scan_ctrl against a slot-level reference model.
module tb_sevenseg_scan_ctrl;

  localparam int DIV = 8;
  localparam int GH  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] port_id = '0;
  logic [7:0] out_port = '0;
  logic       write_strobe = 1'b0;
  logic [7:0] seg;
  logic [3:0] en;
  logic       slot_tick;

  sevenseg_scan_ctrl #(
    .BASE_PORT   (8'h83),
    .REFRESH_DIV (DIV),
    .GHOST_CYCLES(GH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .port_id     (port_id),
    .out_port    (out_port),
    .write_strobe(write_strobe),
    .seg         (seg),
    .en          (en),
    .slot_tick   (slot_tick)
  );

  always #5 clk = ~clk;

  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int unsigned n;
  logic [3:0]  mdig [4];
  logic [3:0]  mblank, mdp;
  logic [7:0]  exp_seg;
  logic [3:0]  exp_en;
  logic        exp_tick;
  int          n_checks = 0;
  int          n_fail   = 0;

  // One clock: predicts outputs from the pre-edge slot position, then applies the write.
  task automatic tick(input logic r, input logic w, input logic [7:0] p, input logic [7:0] d);
    int pos, dg;
    rst = r; write_strobe = w; port_id = p; out_port = d;
    pos = int'(n % DIV);
    dg  = int'((n / DIV) % 4);
    exp_seg = 8'hFF; exp_en = 4'hF; exp_tick = 1'b0;
    if (!r) begin
      exp_tick = (pos == DIV - 1);
      if (pos >= GH && !mblank[dg]) begin
        exp_en  = 4'hF ^ (4'b0001 << dg);
        exp_seg = {~mdp[dg], hex_tab[mdig[dg]]};
      end
    end
    @(posedge clk);
    if (r) begin
      n = 0;
      for (int i = 0; i < 4; i++) mdig[i] = '0;
      mblank = '0;
      mdp = '0;
    end else begin
      if (w) begin
        if (p >= 8'h83 && p <= 8'h86) mdig[int'(p - 8'h83)] = d[3:0];
        else if (p == 8'h87) mblank = d[3:0];
        else if (p == 8'h88) mdp = d[3:0];
      end
      n++;
    end
    #1;
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b1, 8'h83, 8'h05);
    n_checks++; if (seg !== 8'hFF) begin n_fail++; $display("FAIL reset_seg got %h expected ff", seg); end
    n_checks++; if (en !== 4'hF) begin n_fail++; $display("FAIL reset_en got %b expected 1111", en); end
    n_checks++; if (slot_tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick got %b expected 0", slot_tick); end
  endtask

  task automatic test_scan();
    for (int c = 0; c < 40; c++) begin
      tick(1'b0, 1'b0, 8'h00, 8'h00);
      n_checks++; if (seg !== exp_seg) begin n_fail++; $display("FAIL scan_seg n=%0d got %h expected %h", n, seg, exp_seg); end
      n_checks++; if (en !== exp_en) begin n_fail++; $display("FAIL scan_en n=%0d got %b expected %b", n, en, exp_en); end
      n_checks++; if (slot_tick !== exp_tick) begin n_fail++; $display("FAIL scan_tick n=%0d got %b expected %b", n, slot_tick, exp_tick); end
      if (en != 4'hF) begin
        n_checks++; if (seg !== 8'hC0) begin n_fail++; $display("FAIL scan_zero n=%0d got %h expected c0", n, seg); end
      end
    end
  endtask

  task automatic test_digits();
    tick(1'b0, 1'b1, 8'h83, 8'h03);
    tick(1'b0, 1'b1, 8'h84, 8'h1A);
    tick(1'b0, 1'b1, 8'h85, 8'h2F);
    tick(1'b0, 1'b1, 8'h86, 8'h38);
    for (int c = 0; c < 40; c++) begin
      tick(1'b0, 1'b0, 8'h00, 8'h00);
      n_checks++; if (seg !== exp_seg) begin n_fail++; $display("FAIL digits_seg n=%0d got %h expected %h", n, seg, exp_seg); end
      n_checks++; if (en !== exp_en) begin n_fail++; $display("FAIL digits_en n=%0d got %b expected %b", n, en, exp_en); end
      if (c >= 8) begin
        case (en)
          4'b1110: begin n_checks++; if (seg !== 8'hB0) begin n_fail++; $display("FAIL digits_d0 got %h expected b0", seg); end end
          4'b1101: begin n_checks++; if (seg !== 8'h88) begin n_fail++; $display("FAIL digits_d1 got %h expected 88", seg); end end
          4'b1011: begin n_checks++; if (seg !== 8'h8E) begin n_fail++; $display("FAIL digits_d2 got %h expected 8e", seg); end end
          4'b0111: begin n_checks++; if (seg !== 8'h80) begin n_fail++; $display("FAIL digits_d3 got %h expected 80", seg); end end
          default: ;
        endcase
      end
    end
  endtask

  task automatic test_blank_dp();
    tick(1'b0, 1'b1, 8'h87, 8'h05);
    for (int c = 0; c < 40; c++) begin
      tick(1'b0, 1'b0, 8'h00, 8'h00);
      n_checks++; if (en !== exp_en) begin n_fail++; $display("FAIL blank_en n=%0d got %b expected %b", n, en, exp_en); end
      n_checks++; if (en === 4'b1110 || en === 4'b1011) begin n_fail++; $display("FAIL blank_dark n=%0d got %b expected digits 0/2 off", n, en); end
    end
    tick(1'b0, 1'b1, 8'h88, 8'h02);
    for (int c = 0; c < 40; c++) begin
      tick(1'b0, 1'b0, 8'h00, 8'h00);
      n_checks++; if (seg !== exp_seg) begin n_fail++; $display("FAIL dp_seg n=%0d got %h expected %h", n, seg, exp_seg); end
      if (en == 4'b1101) begin
        n_checks++; if (seg[7] !== 1'b0) begin n_fail++; $display("FAIL dp_bit got %b expected 0", seg[7]); end
      end
    end
  endtask

  task automatic test_ignore();
    tick(1'b0, 1'b1, 8'h90, 8'h07);
    tick(1'b0, 1'b1, 8'h82, 8'h07);
    tick(1'b0, 1'b0, 8'h83, 8'h07);
    for (int c = 0; c < 40; c++) begin
      tick(1'b0, 1'b0, 8'h83, 8'h07);
      n_checks++; if (seg !== exp_seg) begin n_fail++; $display("FAIL ignore_seg n=%0d got %h expected %h", n, seg, exp_seg); end
      n_checks++; if (en !== exp_en) begin n_fail++; $display("FAIL ignore_en n=%0d got %b expected %b", n, en, exp_en); end
    end
  endtask

  task automatic test_midslot();
    tick(1'b1, 1'b0, 8'h00, 8'h00);
    while (n != 4) tick(1'b0, 1'b0, 8'h00, 8'h00);
    tick(1'b0, 1'b1, 8'h83, 8'h09);
    n_checks++; if (seg !== 8'hC0) begin n_fail++; $display("FAIL midslot_old got %h expected c0", seg); end
    tick(1'b0, 1'b0, 8'h00, 8'h00);
    n_checks++; if (seg !== 8'h90) begin n_fail++; $display("FAIL midslot_new got %h expected 90", seg); end
    n_checks++; if (en !== 4'b1110) begin n_fail++; $display("FAIL midslot_en got %b expected 1110", en); end
    for (int c = 0; c < 12; c++) begin
      tick(1'b0, 1'b0, 8'h00, 8'h00);
      n_checks++; if (seg !== exp_seg) begin n_fail++; $display("FAIL midslot_seg n=%0d got %h expected %h", n, seg, exp_seg); end
      n_checks++; if (slot_tick !== exp_tick) begin n_fail++; $display("FAIL midslot_tick n=%0d got %b expected %b", n, slot_tick, exp_tick); end
    end
  endtask

  task automatic test_reset_mid();
    while (n % 32 != 20) tick(1'b0, 1'b0, 8'h00, 8'h00);
    tick(1'b1, 1'b1, 8'h85, 8'h07);
    n_checks++; if (seg !== 8'hFF) begin n_fail++; $display("FAIL rstmid_seg got %h expected ff", seg); end
    n_checks++; if (en !== 4'hF) begin n_fail++; $display("FAIL rstmid_en got %b expected 1111", en); end
    for (int c = 1; c <= 3; c++) begin
      tick(1'b0, 1'b0, 8'h00, 8'h00);
      n_checks++;
      if (en !== ((c == 3) ? 4'b1110 : 4'b1111)) begin
        n_fail++; $display("FAIL rstmid_edge%0d got %b expected %b", c, en, (c == 3) ? 4'b1110 : 4'b1111);
      end
    end
    while (n < 22) tick(1'b0, 1'b0, 8'h00, 8'h00);
    n_checks++; if (en !== 4'b1011) begin n_fail++; $display("FAIL rstmid_d2en got %b expected 1011", en); end
    n_checks++; if (seg !== 8'hC0) begin n_fail++; $display("FAIL rstmid_d2seg got %h expected c0", seg); end
  endtask

  task automatic test_random();
    logic r, w;
    logic [7:0] p, d;
    for (int c = 0; c < 400; c++) begin
      r = ($urandom_range(0, 59) == 0);
      w = 1'($urandom_range(0, 1));
      p = 8'h81 + 8'($urandom_range(0, 9));
      d = 8'($urandom);
      tick(r, w, p, d);
      n_checks++; if (seg !== exp_seg) begin n_fail++; $display("FAIL rand_seg n=%0d got %h expected %h", n, seg, exp_seg); end
      n_checks++; if (en !== exp_en) begin n_fail++; $display("FAIL rand_en n=%0d got %b expected %b", n, en, exp_en); end
      n_checks++; if (slot_tick !== exp_tick) begin n_fail++; $display("FAIL rand_tick n=%0d got %b expected %b", n, slot_tick, exp_tick); end
      n_checks++; if ($countones(~en) > 1) begin n_fail++; $display("FAIL rand_onehot got %b expected at most one low", en); end
    end
  endtask

  initial begin
    n = 0;
    for (int i = 0; i < 4; i++) mdig[i] = '0;
    mblank = '0;
    mdp = '0;
    test_reset();
    test_scan();
    test_digits();
    test_blank_dp();
    test_ignore();
    test_midslot();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
